// File: rtl/counter_sweep_pkg.sv
// counter_sweep_pkg
//   Shared types and constants for the counter sweep sequencer.
//   - sweep_state_t      : sequencer FSM states, 2-bit encoding
//   - PERIODS_CONTINUOUS : period-count request meaning "run until abort"
package counter_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } sweep_state_t;

    localparam int PERIODS_CONTINUOUS = 0;

endpackage

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//   Sequencer for the up/down counter (reverse_counter). It drives the
//   counter's load and direction inputs so the counter sweeps a triangle
//   lo..hi..lo for a requested number of periods. The counter has no enable,
//   so whenever the sweep is not advancing this block reloads the counter
//   with its own value to hold it.
//
//   Optional build macro: SWEEP_PAUSE_EN adds pause_i, which freezes the
//   sweep (counter, state, progress) while high in UP/DOWN.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   start_i          start request, sampled only in IDLE
//   abort_i          stop the sweep, wins over start_i and pause_i
//   pause_i          (SWEEP_PAUSE_EN only) hold the sweep in place
//   lo_i, hi_i       sweep limits, latched on an accepted start
//   periods_i        full periods to run, 0 = continuous
//   busy_o           high while in LOAD/UP/DOWN (registered)
//   done_o           one-cycle pulse after normal completion (registered)
//   cfg_err_o        one-cycle pulse after a rejected start (registered)
//   period_cnt_o     completed periods of the current/last sweep
//   cnt_i            counter value (counter cnt_o)
//   cnt_set_data_o   to counter set_value_data_i (combinational)
//   cnt_set_en_o     to counter set_value_en_i   (combinational)
//   cnt_reverse_o    to counter reverse_i        (combinational)
//
// Control handshake: start_i is a level sampled every IDLE cycle; it is
// accepted when abort_i is low and hi_i > lo_i, otherwise cfg_err_o pulses.
// start_i while busy is ignored. abort_i in any busy state freezes the
// counter that same cycle and returns to IDLE without a done_o pulse.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PER_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
`ifdef SWEEP_PAUSE_EN
    input  logic                 pause_i,
`endif
    input  logic [CNT_WIDTH-1:0] lo_i,
    input  logic [CNT_WIDTH-1:0] hi_i,
    input  logic [PER_WIDTH-1:0] periods_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cfg_err_o,
    output logic [PER_WIDTH-1:0] period_cnt_o,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    output logic [CNT_WIDTH-1:0] cnt_set_data_o,
    output logic                 cnt_set_en_o,
    output logic                 cnt_reverse_o
);

    sweep_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] lo_q, hi_q;
    logic [PER_WIDTH-1:0] periods_q;

    logic                 pause;
    logic                 at_lo, at_hi;
    logic                 last_period;
    logic [PER_WIDTH-1:0] period_inc;

    // Per-cycle events produced by the next-state logic.
    logic start_ok;    // accepted start: latch config
    logic start_rej;   // rejected start: pulse cfg_err_o
    logic period_end;  // a full period just completed
    logic finish;      // the final period completed

`ifdef SWEEP_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif

    assign at_lo       = (cnt_i == lo_q);
    assign at_hi       = (cnt_i == hi_q);
    assign period_inc  = period_cnt_o + 1'b1;
    assign last_period = (periods_q != PER_WIDTH'(PERIODS_CONTINUOUS)) &&
                         (period_inc == periods_q);

    always_comb begin
        state_d        = state_q;
        cnt_set_en_o   = 1'b0;
        cnt_set_data_o = cnt_i;
        cnt_reverse_o  = 1'b0;
        start_ok       = 1'b0;
        start_rej      = 1'b0;
        period_end     = 1'b0;
        finish         = 1'b0;

        case (state_q)
            IDLE: begin
                // Reload with own value: the counter has no enable.
                cnt_set_en_o = 1'b1;
                if (start_i && !abort_i) begin
                    if (hi_i > lo_i) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_rej = 1'b1;
                    end
                end
            end

            LOAD: begin
                cnt_set_en_o = 1'b1;
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_set_data_o = lo_q;
                    state_d        = UP;
                end
            end

            UP: begin
                if (abort_i) begin
                    cnt_set_en_o = 1'b1;
                    state_d      = IDLE;
                end else if (pause) begin
                    cnt_set_en_o = 1'b1;
                end else begin
                    // Reverse on the cycle hi is seen so the next value is hi-1.
                    cnt_reverse_o = at_hi;
                    if (at_hi) begin
                        state_d = DOWN;
                    end
                end
            end

            DOWN: begin
                if (abort_i) begin
                    cnt_set_en_o = 1'b1;
                    state_d      = IDLE;
                end else if (pause) begin
                    cnt_set_en_o = 1'b1;
                end else if (at_lo) begin
                    period_end = 1'b1;
                    if (last_period) begin
                        cnt_set_en_o = 1'b1;
                        finish       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = UP;
                    end
                end else begin
                    cnt_reverse_o = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            periods_q    <= '0;
            period_cnt_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_o    <= (state_d != IDLE);
            done_o    <= finish;
            cfg_err_o <= start_rej;
            if (start_ok) begin
                lo_q         <= lo_i;
                hi_q         <= hi_i;
                periods_q    <= periods_i;
                period_cnt_o <= '0;
            end else if (period_end) begin
                // Wraps naturally in continuous mode.
                period_cnt_o <= period_inc;
            end
        end
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the team's up/down counter (`reverse_counter`): drives its load and direction inputs so the counter produces a triangle sweep between programmable limits lo..hi for N periods.
- The counter has no enable, so this block also holds the counter value when idle or paused.
- Sits beside the counter in scan/sweep datapaths. Software-style start/abort handshake on the control side.

Parameters:
- CNT_WIDTH, 32, counter/limit width; must equal the controlled counter's CNT_WIDTH.
- PER_WIDTH, 16, width of the period-count request and the progress counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- start_i  in  1  start request; sampled in IDLE only
- abort_i  in  1  stop the sweep; priority over start_i
- lo_i  in  CNT_WIDTH  lower limit, latched on accepted start
- hi_i  in  CNT_WIDTH  upper limit, latched on accepted start
- periods_i  in  PER_WIDTH  full periods to run; 0 = continuous until abort
- busy_o  out  1  high in LOAD/UP/DOWN
- done_o  out  1  one-cycle pulse on normal completion
- cfg_err_o  out  1  one-cycle pulse when a start is rejected
- period_cnt_o  out  PER_WIDTH  completed periods of the current/last sweep
- cnt_i  in  CNT_WIDTH  current counter value (counter cnt_o)
- cnt_set_data_o  out  CNT_WIDTH  to counter set_value_data_i
- cnt_set_en_o  out  1  to counter set_value_en_i
- cnt_reverse_o  out  1  to counter reverse_i

Behaviour:
- Reset is asynchronous, active low, on rst_n_i; the clock is clk_i.
- Reset values: state=IDLE, lo_q/hi_q/periods_q=0, period_cnt_o=0, done_o=0, cfg_err_o=0, busy_o=0.
- Counter-side outputs are combinational from state and cnt_i. All other outputs are registered.
- State IDLE:
  - Drives cnt_set_en_o=1, cnt_set_data_o=cnt_i, cnt_reverse_o=0, which holds the counter.
  - On start_i & !abort_i:
    - If hi_i > lo_i (unsigned): latch the config, clear period_cnt_o, go to LOAD.
    - Otherwise: pulse cfg_err_o next cycle and stay in IDLE.
- State LOAD (1 cycle): cnt_set_en_o=1, cnt_set_data_o=lo_q; next state is UP. cnt_i==lo_q is visible 2 cycles after the start cycle.
- State UP:
  - cnt_set_en_o=0; cnt_reverse_o=(cnt_i==hi_q).
  - If cnt_i==hi_q, go to DOWN. There is no overshoot: the value after hi is hi-1.
- State DOWN, while cnt_i!=lo_q: cnt_set_en_o=0, cnt_reverse_o=1.
- State DOWN, when cnt_i==lo_q (period end):
  - period_cnt_o increments.
  - If periods_q!=0 and period_cnt_o+1==periods_q: drive cnt_set_en_o=1 with data=cnt_i (hold at lo), go to IDLE, and pulse done_o the next cycle.
  - Otherwise: cnt_reverse_o=0, go to UP.
- Sequence for lo=L, hi=H: L, L+1..H, H-1..L, repeat. The period is 2*(H-L) cycles.
- Continuous mode (periods 0): period_cnt_o wraps modulo 2^PER_WIDTH.
- abort_i in LOAD/UP/DOWN:
  - The same cycle drives cnt_set_en_o=1 with data=cnt_i, freezing the counter.
  - Next state is IDLE. No done_o pulse; period_cnt_o is kept.
- start_i while busy is ignored.
- Reset mid-sweep: IDLE immediately. The counter's own reset governs its value.
- done_o and cfg_err_o are never both high.

Optional Feature:
- SWEEP_PAUSE_EN defined: adds input pause_i (1 bit). In UP/DOWN, pause_i=1 drives cnt_set_en_o=1, data=cnt_i.
  - State, period_cnt_o and the turnaround logic freeze.
  - Resume continues from the held value with the same direction.
  - abort_i overrides pause_i.
- Undefined: no pause_i port; the sweep runs uninterrupted.

Decomposition:
- Package counter_sweep_pkg holds:
  - state enum sweep_state_t {IDLE, LOAD, UP, DOWN}, encoded in 2 bits;
  - localparam PERIODS_CONTINUOUS = 0.
- Single module; no sub-module needed.
- The bench instantiates counter_sweep_ctrl with the real up/down counter as a closed loop.

Test Plan:
- lo=2, hi=5, periods=2, start pulse -> cnt: 2,3,4,5,4,3,2,3,4,5,4,3,2 then held at 2; done_o one pulse the cycle after the final 2; period_cnt_o=2; busy_o low with done_o.
- hi=lo=7, start -> cfg_err_o one pulse; busy_o stays 0; counter unchanged.
- lo=0, hi=10, periods=0, abort when cnt=6 while counting up -> cnt holds 6 from the abort cycle on; no done_o; IDLE.
- start while busy (lo=2, hi=5 running), second start with lo=0 -> ignored; the sweep stays 2..5.
- rst_n_i low for 1 cycle mid-DOWN -> busy_o=0 and period_cnt_o=0 asynchronously; the counter then holds its post-reset value 0.
- lo=0xFFFFFFFD, hi=0xFFFFFFFF, periods=1 -> cnt FD,FE,FF,FE,FD with no wrap; done_o pulse.
- SWEEP_PAUSE_EN: pause 3 cycles at cnt=4 going up -> cnt 4,4,4,4 then 5,4...; period timing extended by exactly 3 cycles.
